test_reg: RTL and testbench



---
 rtl/test_reg.sv | 87 ++++++++
 tb/tb_test_reg.sv | 122 ++++++++++++
 2 files changed

// File: rtl/test_reg.sv
// -----------------------------------------------------------------------------
// test_reg
//   Single-stage data register with change tracking. Every rising edge of clk
//   captures data_in onto data_out. The block also reports the value data_out
//   held before that capture, a change flag and a saturating count of
//   consecutive captures that produced no change.
//
// Parameters
//   WIDTH      data width in bits (1..64)
//   CNT_WIDTH  stability counter width (2..32)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   data_in     [WIDTH]      value to capture
//   data_out    [WIDTH]      registered copy of data_in
//   data_prev   [WIDTH]      data_out value before its most recent update
//   changed                  high when the latest capture differed from the
//                            previous data_out
//   stable_cnt  [CNT_WIDTH]  consecutive unchanged captures, saturating
//   parity                   XOR-reduce of data_out (only when the macro
//                            TEST_REG_PARITY_EN is defined)
// -----------------------------------------------------------------------------
module test_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     data_out,
    output logic [WIDTH-1:0]     data_prev,
    output logic                 changed,
    output logic [CNT_WIDTH-1:0] stable_cnt
`ifdef TEST_REG_PARITY_EN
    ,
    output logic                 parity
`endif
);

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    logic [WIDTH-1:0]     data_p1;
    logic [WIDTH-1:0]     prev_p1;
    logic                 chg_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;
    logic                 diff_p0;

    // Stage 0 -> 1: compare the incoming word against what is currently held.
    assign diff_p0 = (data_in != data_p1);

    // Data registers are reset too: the reset state of data_out is observable
    // and is the reference for the first post-reset comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            prev_p1 <= '0;
            chg_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            data_p1 <= data_in;
            prev_p1 <= data_p1;
            chg_p1  <= diff_p0;
            cnt_p1  <= diff_p0 ? '0 : sat_inc(cnt_p1);
        end
    end

    // Stage 1 outputs: all driven straight from registers.
    assign data_out   = data_p1;
    assign data_prev  = prev_p1;
    assign changed    = chg_p1;
    assign stable_cnt = cnt_p1;

`ifdef TEST_REG_PARITY_EN
    assign parity = ^data_p1;
`endif

endmodule

// File: tb/tb_test_reg.sv
// -----------------------------------------------------------------------------
// tb_test_reg
//   Directed-vector bench for test_reg (WIDTH=8, CNT_WIDTH=4). Inputs change on
//   the falling edge; outputs are sampled 1 ns after the rising edge. Parity
//   checks are compiled in only when TEST_REG_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_test_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'hFF;
    logic [7:0] data_out;
    logic [7:0] data_prev;
    logic       changed;
    logic [3:0] stable_cnt;
`ifdef TEST_REG_PARITY_EN
    logic       parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    test_reg #(
        .WIDTH    (8),
        .CNT_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_prev (data_prev),
        .changed   (changed),
        .stable_cnt(stable_cnt)
`ifdef TEST_REG_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one vector for exactly one rising edge, then settle past it.
    task automatic tick(input logic r, input logic [7:0] d);
        @(negedge clk);
        rst     = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_out, input logic [7:0] e_prev,
                           input logic e_chg, input logic [3:0] e_cnt);
        chk({tag, "_out"},  64'(data_out),   64'(e_out));
        chk({tag, "_prev"}, 64'(data_prev),  64'(e_prev));
        chk({tag, "_chg"},  64'(changed),    64'(e_chg));
        chk({tag, "_cnt"},  64'(stable_cnt), 64'(e_cnt));
    endtask

    initial begin
        // Reset held for two edges with all-ones on the input.
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hFF);
        chk_all("reset", 8'h00, 8'h00, 1'b0, 4'd0);
`ifdef TEST_REG_PARITY_EN
        chk("reset_par", 64'(parity), 64'(0));
`endif

        // Basic capture: each value held for two edges.
        tick(1'b0, 8'h05); chk_all("cap05a", 8'h05, 8'h00, 1'b1, 4'd0);
        tick(1'b0, 8'h05); chk_all("cap05b", 8'h05, 8'h05, 1'b0, 4'd1);
        tick(1'b0, 8'h0A); chk_all("cap0Aa", 8'h0A, 8'h05, 1'b1, 4'd0);
        tick(1'b0, 8'h0A); chk_all("cap0Ab", 8'h0A, 8'h0A, 1'b0, 4'd1);
        tick(1'b0, 8'h03); chk_all("cap03a", 8'h03, 8'h0A, 1'b1, 4'd0);
`ifdef TEST_REG_PARITY_EN
        chk("par03", 64'(parity), 64'(0));
`endif
        tick(1'b0, 8'h03); chk_all("cap03b", 8'h03, 8'h03, 1'b0, 4'd1);
        tick(1'b0, 8'h07); chk_all("cap07", 8'h07, 8'h03, 1'b1, 4'd0);
`ifdef TEST_REG_PARITY_EN
        chk("par07", 64'(parity), 64'(1));
`endif

        // Saturation: reset, then zeros for 20 edges; counter goes 1..15 and holds.
        tick(1'b1, 8'h00);
        chk_all("rst2", 8'h00, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00);
            chk("sat_cnt", 64'(stable_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
            chk("sat_chg", 64'(changed), 64'(0));
        end

        // A change clears the saturated counter; a repeat restarts it at 1.
        tick(1'b0, 8'hA5); chk_all("a5a", 8'hA5, 8'h00, 1'b1, 4'd0);
        tick(1'b0, 8'hA5); chk_all("a5b", 8'hA5, 8'hA5, 1'b0, 4'd1);

        // Mid-stream reset overrides the pending capture of 8'h03.
        tick(1'b0, 8'h0A); chk_all("pre_rst", 8'h0A, 8'hA5, 1'b1, 4'd0);
        tick(1'b1, 8'h03); chk_all("mid_rst", 8'h00, 8'h00, 1'b0, 4'd0);
        tick(1'b0, 8'h03); chk_all("post_rst", 8'h03, 8'h00, 1'b1, 4'd0);

        // A glitch between edges is not captured.
        @(negedge clk);
        data_in = 8'hFF;
        #2;
        data_in = 8'h03;
        @(posedge clk);
        #1;
        chk_all("glitch", 8'h03, 8'h03, 1'b0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
